// File: rtl/dm_arb_pkg.sv
// Shared definitions for the dm_arbiter block: FSM encoding, port ids, default widths.
package dm_arb_pkg;

    localparam int DM_AW = 10;
    localparam int DM_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_D = 1'b1;

    // Word accesses must be 4-byte aligned; byte accesses are legal anywhere.
    function automatic logic is_misaligned(input logic sb, input logic [1:0] addr_lsb);
        return !sb && (addr_lsb != 2'b00);
    endfunction

endpackage

// File: rtl/dm_arb_pick.sv
// Combinational winner select for dm_arbiter.
// DM_ARB_RR_EN selects round-robin on contention; otherwise port C has fixed priority.
module dm_arb_pick
    import dm_arb_pkg::*;
(
    input  logic c_req,
    input  logic d_req,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = c_req | d_req;
        grant_id    = PORT_C;
`ifdef DM_ARB_RR_EN
        if (c_req && d_req) begin
            grant_id = ~last_grant;
        end else if (d_req) begin
            grant_id = PORT_D;
        end
`else
        if (!c_req && d_req) begin
            grant_id = PORT_D;
        end
`endif
    end

`ifndef DM_ARB_RR_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/dm_arbiter.sv
// Two-port (CPU/DMA) arbiter and access sequencer for the byte-addressed data memory.
// Optional round-robin arbitration with DM_ARB_RR_EN (handled inside dm_arb_pick).
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int AW = DM_AW,
    parameter int DW = DM_DW
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic          c_we,
    input  logic          c_sb,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_ack,
    output logic          c_err,
    output logic [DW-1:0] c_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic          d_sb,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic          d_err,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_din,
    output logic          dm_we,
    output logic          dm_sbsel,
    input  logic [DW-1:0] dm_dout,
    output logic          busy
);

    state_t        state_reg;
    state_t        state_next;

    logic          grant_valid;
    logic          grant_id;
    // Doubles as the round-robin pointer: it only changes on a grant.
    logic          grant_id_reg;
    logic          misalign_reg;

    logic          sel_we;
    logic          sel_sb;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_misalign;

    logic [AW-1:0] dm_addr_reg;
    logic [DW-1:0] dm_din_reg;
    logic          dm_sbsel_reg;
    logic          dm_we_reg;
    logic          busy_reg;

    logic [1:0]    port_hit;
    logic [1:0]    ack_reg;
    logic [1:0]    err_reg;
    logic [DW-1:0] rdata_reg [2];

    dm_arb_pick u_pick (
        .c_req       (c_req),
        .d_req       (d_req),
        .last_grant  (grant_id_reg),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        sel_we    = c_we;
        sel_sb    = c_sb;
        sel_addr  = c_addr;
        sel_wdata = c_wdata;
        if (grant_id == PORT_D) begin
            sel_we    = d_we;
            sel_sb    = d_sb;
            sel_addr  = d_addr;
            sel_wdata = d_wdata;
        end
        sel_misalign = is_misaligned(sel_sb, sel_addr[1:0]);
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (grant_valid) state_next = ST_ACCESS;
            ST_ACCESS: state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next != ST_IDLE);
        end
    end

    // Request latch: the memory-side registers hold the granted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_id_reg <= PORT_D;
            misalign_reg <= 1'b0;
            dm_addr_reg  <= '0;
            dm_din_reg   <= '0;
            dm_sbsel_reg <= 1'b0;
            dm_we_reg    <= 1'b0;
        end else if (state_reg == ST_IDLE && grant_valid) begin
            grant_id_reg <= grant_id;
            misalign_reg <= sel_misalign;
            dm_addr_reg  <= sel_addr;
            dm_din_reg   <= sel_wdata;
            dm_sbsel_reg <= sel_sb;
            dm_we_reg    <= sel_we && !sel_misalign;
        end else begin
            dm_we_reg    <= 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign port_hit[gi] = (state_reg == ST_ACCESS) && (grant_id_reg == 1'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_reg <= '0;
            err_reg <= '0;
            for (int i = 0; i < 2; i++) begin
                rdata_reg[i] <= '0;
            end
        end else begin
            ack_reg <= port_hit;
            err_reg <= port_hit & {2{misalign_reg}};
            for (int i = 0; i < 2; i++) begin
                if (port_hit[i]) begin
                    rdata_reg[i] <= misalign_reg ? '0 : dm_dout;
                end
            end
        end
    end

    // Reset in the ACCESS cycle must stop the memory from taking the write on that edge.
    assign dm_we    = dm_we_reg && !rst;
    assign dm_addr  = dm_addr_reg;
    assign dm_din   = dm_din_reg;
    assign dm_sbsel = dm_sbsel_reg;
    assign busy     = busy_reg;

    assign c_ack   = ack_reg[0];
    assign c_err   = err_reg[0];
    assign c_rdata = rdata_reg[0];
    assign d_ack   = ack_reg[1];
    assign d_err   = err_reg[1];
    assign d_rdata = rdata_reg[1];

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed testbench for dm_arbiter with a behavioural 1 KB little-endian data memory.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_we, c_sb;
    logic [9:0]  c_addr;
    logic [31:0] c_wdata;
    logic        c_ack, c_err;
    logic [31:0] c_rdata;
    logic        d_req, d_we, d_sb;
    logic [9:0]  d_addr;
    logic [31:0] d_wdata;
    logic        d_ack, d_err;
    logic [31:0] d_rdata;
    logic [9:0]  dm_addr;
    logic [31:0] dm_din;
    logic        dm_we, dm_sbsel;
    logic [31:0] dm_dout;
    logic        busy;

    logic [7:0]  mem [1024];
    logic [9:0]  rd_base;
    int          we_count = 0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    dm_arbiter dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_sb(c_sb), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(c_ack), .c_err(c_err), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_sb(d_sb), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
        .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we), .dm_sbsel(dm_sbsel),
        .dm_dout(dm_dout), .busy(busy)
    );

    // Memory: word read from the aligned base, byte or word write on the clock edge.
    assign rd_base = {dm_addr[9:2], 2'b00};
    assign dm_dout = {mem[rd_base + 10'd3], mem[rd_base + 10'd2], mem[rd_base + 10'd1], mem[rd_base]};

    always @(posedge clk) begin
        if (dm_we === 1'b1) begin
            if (dm_sbsel) begin
                mem[dm_addr] <= dm_din[7:0];
            end else begin
                mem[dm_addr]         <= dm_din[7:0];
                mem[dm_addr + 10'd1] <= dm_din[15:8];
                mem[dm_addr + 10'd2] <= dm_din[23:16];
                mem[dm_addr + 10'd3] <= dm_din[31:24];
            end
        end
    end

    always @(negedge clk) begin
        if (dm_we === 1'b1) we_count++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic port, input logic we, input logic sb,
                         input logic [9:0] addr, input logic [31:0] wdata);
        if (port == 1'b0) begin
            c_req = 1'b1; c_we = we; c_sb = sb; c_addr = addr; c_wdata = wdata;
        end else begin
            d_req = 1'b1; d_we = we; d_sb = sb; d_addr = addr; d_wdata = wdata;
        end
    endtask

    // Waits (bounded) for the ack of an already-driven request and checks it.
    task automatic wait_ack(input string tag, input logic port, input logic exp_err,
                            input logic [31:0] exp_rd, input bit chk_rd,
                            input int exp_we, input bit corrupt);
        int lat = 0;
        int we0 = we_count;
        logic ack = 1'b0;
        while (lat < 8) begin
            @(posedge clk); #1;
            lat++;
            if (corrupt && lat == 1) begin
                if (port == 1'b0) begin c_addr = 10'h030; c_wdata = 32'hFFFF_FFFF; end
                else begin d_addr = 10'h030; d_wdata = 32'hFFFF_FFFF; end
            end
            ack = port ? d_ack : c_ack;
            if (ack) break;
        end
        check({tag, "_latency"}, lat, 2);
        check({tag, "_err"}, port ? d_err : c_err, exp_err);
        check({tag, "_other_ack"}, port ? c_ack : d_ack, 1'b0);
        check({tag, "_busy_done"}, busy, 1'b1);
        if (chk_rd) check({tag, "_rdata"}, port ? d_rdata : c_rdata, exp_rd);
        check({tag, "_we_cycles"}, we_count - we0, exp_we);
        $display("xact %s port=%s lat=%0d err=%0b rdata=%h we_cycles=%0d", tag,
                 port ? "D" : "C", lat, port ? d_err : c_err, port ? d_rdata : c_rdata,
                 we_count - we0);
        if (port == 1'b0) c_req = 1'b0; else d_req = 1'b0;
        @(posedge clk); #1;
        check({tag, "_ack_pulse"}, port ? d_ack : c_ack, 1'b0);
        check({tag, "_busy_idle"}, busy, 1'b0);
    endtask

    task automatic xact(input string tag, input logic port, input logic we, input logic sb,
                        input logic [9:0] addr, input logic [31:0] wdata, input logic exp_err,
                        input logic [31:0] exp_rd, input bit chk_rd, input bit corrupt);
        drive(port, we, sb, addr, wdata);
        wait_ack(tag, port, exp_err, exp_rd, chk_rd, (we && !exp_err) ? 1 : 0, corrupt);
    endtask

    initial begin
        logic exp_c, exp_d;
        int   we0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        rst = 1'b1;
        c_req = 0; c_we = 0; c_sb = 0; c_addr = '0; c_wdata = '0;
        d_req = 0; d_we = 0; d_sb = 0; d_addr = '0; d_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_acks", {c_ack, d_ack, c_err, d_err}, 4'b0);
        check("rst_dm_we", dm_we, 1'b0);
        check("rst_dm_addr", dm_addr, 10'h0);
        check("rst_dm_din", dm_din, 32'h0);
        check("rst_dm_sbsel", dm_sbsel, 1'b0);
        check("rst_rdata", c_rdata | d_rdata, 32'h0);
        rst = 1'b0;

        xact("c_st_word",  1'b0, 1'b1, 1'b0, 10'h010, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 1'b0);
        xact("c_ld_word",  1'b0, 1'b0, 1'b0, 10'h010, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0);
        xact("d_st_word",  1'b1, 1'b1, 1'b0, 10'h010, 32'h1122_3344, 1'b0, 32'h0, 1'b0, 1'b0);
        xact("d_st_byte",  1'b1, 1'b1, 1'b1, 10'h013, 32'h0000_00A5, 1'b0, 32'h0, 1'b0, 1'b0);
        xact("d_ld_word",  1'b1, 1'b0, 1'b0, 10'h010, 32'h0,         1'b0, 32'hA522_3344, 1'b1, 1'b0);
        xact("c_st_misal", 1'b0, 1'b1, 1'b0, 10'h012, 32'h5555_5555, 1'b1, 32'h0, 1'b1, 1'b0);
        xact("c_ld_after", 1'b0, 1'b0, 1'b0, 10'h010, 32'h0,         1'b0, 32'hA522_3344, 1'b1, 1'b0);
        xact("c_ld_byte",  1'b0, 1'b0, 1'b1, 10'h011, 32'h0,         1'b0, 32'hA522_3344, 1'b1, 1'b0);
        check("idle_hold_addr", dm_addr, 10'h011);
        check("idle_hold_sbsel", dm_sbsel, 1'b1);
        xact("d_ld_misal", 1'b1, 1'b0, 1'b0, 10'h001, 32'h0,         1'b1, 32'h0, 1'b1, 1'b0);
        xact("c_st_latch", 1'b0, 1'b1, 1'b0, 10'h020, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 1'b1);
        xact("c_ld_latch", 1'b0, 1'b0, 1'b0, 10'h020, 32'h0,         1'b0, 32'h1234_5678, 1'b1, 1'b0);
        xact("d_ld_noalias", 1'b1, 1'b0, 1'b0, 10'h030, 32'h0,       1'b0, 32'h0, 1'b1, 1'b0);

        // Contention: both ports hold req; acks every 3 cycles starting at cycle 2.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 10'h010, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 10'h020, 32'h0);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            exp_c = 1'b0;
            exp_d = 1'b0;
            if (k >= 2 && (k - 2) % 3 == 0) begin
`ifdef DM_ARB_RR_EN
                if (((k - 2) / 3) % 2 == 1) exp_d = 1'b1; else exp_c = 1'b1;
`else
                exp_c = 1'b1;
`endif
            end
            check($sformatf("contend_c_ack_cyc%0d", k), c_ack, exp_c);
            check($sformatf("contend_d_ack_cyc%0d", k), d_ack, exp_d);
            if (c_ack || d_ack)
                $display("xact contend cyc=%0d c_ack=%0b d_ack=%0b", k, c_ack, d_ack);
        end
        c_req = 1'b0;
        d_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("contend_drain_busy", busy, 1'b0);

        // Reset during the ACCESS cycle of a store.
        drive(1'b0, 1'b1, 1'b0, 10'h040, 32'hCAFE_F00D);
        @(posedge clk); #1;
        check("rstacc_we_before", dm_we, 1'b1);
        we0 = we_count;
        rst = 1'b1;
        #1;
        check("rstacc_we_gated", dm_we, 1'b0);
        @(posedge clk); #1;
        check("rstacc_busy", busy, 1'b0);
        check("rstacc_no_ack", c_ack, 1'b0);
        check("rstacc_we_cycles", we_count - we0, 0);
        $display("xact rst_in_access port=C addr=040 dropped");
        c_we = 1'b0;
        rst = 1'b0;
        wait_ack("rst_pending_ld", 1'b0, 1'b0, 32'h0, 1'b1, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter and access sequencer in front of the 1 KB byte-addressed data memory. It shares the single memory port between the CPU load/store path (port C) and a DMA/debug master (port D). It turns each granted request into one memory access: a registered one-cycle write strobe, or a registered read capture. Results return on a per-port ack with an alignment-error flag.

## Interface
- AW, 10, byte address width (memory depth 2^AW bytes)
- DW, 32, data width (word = 4 bytes, little-endian in memory)

Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- c_req  in  1  CPU request, held until c_ack
- c_we  in  1  1 = store, 0 = load
- c_sb  in  1  1 = byte store (din[7:0] only), 0 = word
- c_addr  in  AW  byte address
- c_wdata  in  DW  store data
- c_ack  out  1  one-cycle completion pulse
- c_err  out  1  valid with c_ack; misaligned word access
- c_rdata  out  DW  load data, valid with c_ack
- d_req, d_we, d_sb, d_addr, d_wdata, d_ack, d_err, d_rdata: same as c_*, for the DMA port
- dm_addr  out  AW  memory address
- dm_din  out  DW  memory write data
- dm_we  out  1  memory write strobe, one cycle
- dm_sbsel  out  1  memory byte-store select
- dm_dout  in  DW  memory read data (combinational from dm_addr)
- busy  out  1  FSM not in IDLE

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: sample c_req/d_req at the clock edge. If either is set, pick a winner, latch its we/sb/addr/wdata and the grant id, then go to ACCESS. If neither is set, stay in IDLE.
- ACCESS:
  - Drive dm_addr, dm_din and dm_sbsel from the latched values.
  - dm_we=1 for exactly this cycle, only for an aligned store.
  - Capture dm_dout into the rdata register at the end of the cycle.
  - Go to DONE.
- DONE: assert ack for the granted port only, with err and rdata valid. Go to IDLE.
- Alignment: a word access (sb=0) with addr[1:0]≠0 is an error. It produces no write and rdata=0, and err=1 with ack. A byte access at any address is legal.
- Loads always read a full word at dm_addr. The requester extracts bytes.
- Arbitration without the RR macro: fixed priority, C over D.
- Simultaneous requests: one port is granted. The loser keeps req high and is serviced in the next IDLE.
- A requester deasserts req on the edge it sees ack. If req is still high in the following IDLE, it is treated as a new transaction.
- Changes to a requester's addr/wdata after its grant are ignored, because the values are latched.
- Reset in any state:
  - FSM goes to IDLE.
  - dm_we=0, all acks/errs=0, all rdata=0, dm_addr/dm_din=0, dm_sbsel=0, busy=0.
  - The RR pointer is set so that C wins next.
  - An in-flight access is dropped without an ack. A write is suppressed if rst is high in its ACCESS cycle.

## Timing
- Request sampled at edge N; ACCESS in cycle N+1; ack pulse in cycle N+2. Fixed latency: 2 cycles request-to-ack.
- Peak throughput: one access per 3 cycles.
- dm_we is registered and high for exactly one cycle. It never glitches and is never high outside ACCESS.
- All outputs are registered. There is no combinational path from any req to any dm_* output.
- Idle dm_* outputs hold their last values. dm_we is 0.

## Configuration
- DM_ARB_RR_EN defined: round-robin arbitration.
  - A one-bit last-grant pointer flips on each grant.
  - On simultaneous requests, the port not granted last wins.
  - A lone requester is always granted.
- DM_ARB_RR_EN undefined: fixed priority, C over D. The pointer logic is compiled out.

## Structure
- Package/header dm_arb_pkg: state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2), port ids (PORT_C=1'b0, PORT_D=1'b1), and the AW/DW defaults.
- Sub-module dm_arb_pick: combinational winner select from (c_req, d_req, last_grant). It contains the only DM_ARB_RR_EN-dependent logic.
- The memory itself is outside the block. The testbench connects the existing data memory to the dm_* ports.

## Test plan
- CPU word store of addr=0x010, data=0xDEADBEEF, then a CPU load of 0x010 → dm_we high for 1 cycle; c_ack 2 cycles after each req; c_rdata=0xDEADBEEF; c_err=0.
- DMA byte store of 0xA5 at addr 0x013 over word 0x11223344 at 0x010, then a DMA load of 0x010 → d_rdata=0xA5223344.
- CPU word store at addr=0x012 → c_ack with c_err=1, dm_we never asserted, memory unchanged.
- c_req and d_req both held continuously → fixed mode: C only, D starved; with DM_ARB_RR_EN: grants alternate C, D, C, D, each acked after 2 cycles.
- rst asserted during ACCESS of a store → no write lands, no ack, busy=0 next cycle; after release a pending c_req is serviced normally.
